// File: rtl/nes_pad_ports_if.sv
// CPU-side bus for the $4016/$4017 controller-port window.
// The CPU decode drives select/qualifiers/write data; the port block returns read data.
interface nes_pad_ports_if;
  logic       CS;
  logic       WR;
  logic       RD;
  logic       ADDR;
  logic [7:0] BUS_IN;
  logic [7:0] DATA;

  modport master (output CS, WR, RD, ADDR, BUS_IN, input DATA);
  modport slave  (input CS, WR, RD, ADDR, BUS_IN, output DATA);
endinterface

// File: rtl/nes_pad_ports.sv
// NES $4016/$4017 controller-port emulation for up to two pads fed from USB-HID keycodes.
// Read data lands 1 cycle after a read-access edge; COMP lags KEYCODES by 1 cycle; no backpressure.
module nes_pad_ports #(
  parameter int             NUM_PADS     = 2,
  parameter int             NUM_KEYS     = 6,
  parameter logic [63:0]    KEYMAP0      = 64'h0A0B171C1A160407,
  parameter logic [63:0]    KEYMAP1      = 64'h0D0E1518520D5150,
  parameter logic [15:0]    TURBO0       = 16'h0F10,
  parameter logic [15:0]    TURBO1       = 16'h0000,
  parameter int             TURBO_DIV    = 3,
  parameter bit             SOCD_NEUTRAL = 1'b1
) (
  input  logic                    clk,
  input  logic                    RESET_N,
  nes_pad_ports_if.slave          bus,
  input  logic                    FRAME_TICK,
  input  logic [8*NUM_KEYS-1:0]   KEYCODES,
  output logic [8*NUM_PADS-1:0]   COMP
);

  logic [8*NUM_PADS-1:0]       comp_d, comp_q;
  logic [NUM_PADS-1:0][7:0]    shreg_q;
  logic [7:0]                  data_q;
  logic                        strobe_q;
  logic                        wr_q, rd_q;
  logic [3:0]                  tcnt_q;
  logic                        phase_q;

  logic wr_acc, rd_acc, wr_edge, rd_edge, rd_bit;
  logic unused_bus;

  assign wr_acc  = bus.CS & bus.WR;
  assign rd_acc  = bus.CS & bus.RD & ~bus.WR;
  assign wr_edge = wr_acc & ~wr_q;
  assign rd_edge = rd_acc & ~rd_q;
  assign unused_bus = ^bus.BUS_IN[7:1];

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    localparam logic [63:0] KM = (p == 0) ? KEYMAP0 : KEYMAP1;
    localparam logic [15:0] TK = (p == 0) ? TURBO0 : TURBO1;
    logic [7:0] raw, socd, fin;
    logic       turbo_a, turbo_b;

    always_comb begin
      raw     = 8'h00;
      turbo_a = 1'b0;
      turbo_b = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        for (int b = 0; b < 8; b++) begin
          if (KM[8*b +: 8] != 8'h00 && KEYCODES[8*k +: 8] == KM[8*b +: 8]) raw[b] = 1'b1;
        end
        if (TK[15:8] != 8'h00 && KEYCODES[8*k +: 8] == TK[15:8]) turbo_a = 1'b1;
        if (TK[7:0]  != 8'h00 && KEYCODES[8*k +: 8] == TK[7:0])  turbo_b = 1'b1;
      end
      // Bits: 7=A 6=B 5=Sel 4=Start 3=U 2=D 1=L 0=R; opposing pairs cancel before turbo.
      socd = raw;
      if (SOCD_NEUTRAL) begin
        if (raw[3] & raw[2]) socd[3:2] = 2'b00;
        if (raw[1] & raw[0]) socd[1:0] = 2'b00;
      end
      fin    = socd;
      fin[7] = socd[7] | (turbo_a & phase_q);
      fin[6] = socd[6] | (turbo_b & phase_q);
    end

    assign comp_d[8*p +: 8] = fin;
  end

  // Pads beyond NUM_PADS read as zero.
  always_comb begin
    rd_bit = 1'b0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (bus.ADDR == 1'(p)) rd_bit = shreg_q[p][7];
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      comp_q   <= '0;
      shreg_q  <= '0;
      data_q   <= 8'h00;
      strobe_q <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      tcnt_q   <= 4'd0;
      phase_q  <= 1'b0;
    end else begin
      comp_q <= comp_d;
      wr_q   <= wr_acc;
      rd_q   <= rd_acc;

      if (FRAME_TICK) begin
        if (tcnt_q == 4'(TURBO_DIV - 1)) begin
          tcnt_q  <= 4'd0;
          phase_q <= ~phase_q;
        end else begin
          tcnt_q <= tcnt_q + 4'd1;
        end
      end

      if (wr_edge && !bus.ADDR) strobe_q <= bus.BUS_IN[0];

      if (rd_edge) data_q <= {7'd0, rd_bit};

      // Strobe high keeps reloading, so reads under strobe return the live A bit.
      for (int p = 0; p < NUM_PADS; p++) begin
        if (strobe_q) begin
          shreg_q[p] <= comp_q[8*p +: 8];
        end else if (rd_edge && bus.ADDR == 1'(p)) begin
          shreg_q[p] <= {shreg_q[p][6:0], 1'b1};
        end
      end
    end
  end

  assign COMP     = comp_q;
  assign bus.DATA = data_q;

endmodule

// File: tb/tb_nes_pad_ports.sv
// Directed bench for nes_pad_ports: a default two-pad instance and a one-pad, SOCD-passthrough instance.
module tb_nes_pad_ports;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [47:0] keys;
  logic [15:0] comp0;
  logic [7:0]  comp1;
  logic [7:0]  d0, d1;

  int n_vec = 0;
  int n_err = 0;

  nes_pad_ports_if bus0 ();
  nes_pad_ports_if bus1 ();

  nes_pad_ports u_dut (
    .clk(clk), .RESET_N(rst_n), .bus(bus0), .FRAME_TICK(frame_tick),
    .KEYCODES(keys), .COMP(comp0)
  );

  nes_pad_ports #(.NUM_PADS(1), .SOCD_NEUTRAL(1'b0)) u_ns (
    .clk(clk), .RESET_N(rst_n), .bus(bus1), .FRAME_TICK(frame_tick),
    .KEYCODES(keys), .COMP(comp1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] keys;
    logic [15:0] comp;
    logic [7:0]  comp_ns;
  } vec_t;

  vec_t vt [10];
  int   e2 [10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic cs, input logic wr, input logic rd, input logic a, input logic [7:0] din);
    bus0.CS = cs; bus0.WR = wr; bus0.RD = rd; bus0.ADDR = a; bus0.BUS_IN = din;
    bus1.CS = cs; bus1.WR = wr; bus1.RD = rd; bus1.ADDR = a; bus1.BUS_IN = din;
  endtask

  task automatic wr_reg(input logic a, input logic [7:0] v);
    set_bus(1'b1, 1'b1, 1'b0, a, v);
    cyc();
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc();
  endtask

  task automatic rd_reg(input logic a, output logic [7:0] r0, output logic [7:0] r1);
    set_bus(1'b1, 1'b0, 1'b1, a, 8'h00);
    cyc();
    r0 = bus0.DATA;
    r1 = bus1.DATA;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc();
  endtask

  initial begin
    vt[0] = '{48'h000000_000000, 16'h0000, 8'h00};
    vt[1] = '{48'h000007_00000A, 16'h0081, 8'h81};
    vt[2] = '{48'h000000_04161A, 16'h0002, 8'h0E};
    vt[3] = '{48'h000000_000407, 16'h0000, 8'h03};
    vt[4] = '{48'h00001A_160407, 16'h0000, 8'h0F};
    vt[5] = '{48'h000000_00520D, 16'h8000, 8'h00};
    vt[6] = '{48'h000000_0B171C, 16'h0070, 8'h70};
    vt[7] = '{48'h000000_00000F, 16'h0000, 8'h00};
    vt[8] = '{48'h0A0B17_1C0D0E, 16'hC4F0, 8'hF0};
    vt[9] = '{48'h070000_000000, 16'h0001, 8'h01};
    e2    = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    rst_n      = 1'b0;
    frame_tick = 1'b0;
    keys       = 48'h000000_00000A;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset with a key held, then release.
    cyc(); cyc();
    chk("reset_comp", comp0, 16'h0000);
    chk("reset_data", 16'(bus0.DATA), 16'h0000);
    chk("reset_comp_ns", 16'(comp1), 16'h0000);
    rst_n = 1'b1;
    cyc();
    chk("release_comp", comp0, 16'h0080);

    // Mapping / SOCD table.
    for (int i = 0; i < 10; i++) begin
      keys = vt[i].keys;
      cyc();
      chk($sformatf("map%0d_comp", i), comp0, vt[i].comp);
      chk($sformatf("map%0d_comp_ns", i), 16'(comp1), 16'(vt[i].comp_ns));
    end

    // Latch G+D, read ten bits; keys and a $4017 write change mid-sequence.
    keys = 48'h000007_00000A;
    cyc();
    wr_reg(1'b0, 8'h01);
    wr_reg(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      rd_reg(1'b0, d0, d1);
      chk($sformatf("serial_rd%0d", i), 16'(d0), 16'(e2[i]));
      if (i == 1) begin
        keys = 48'h0;
        wr_reg(1'b1, 8'h01);
      end
    end

    // Turbo A: phase toggles every third frame tick.
    keys = 48'h000000_00000F;
    cyc();
    for (int i = 1; i <= 12; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
      chk($sformatf("turbo_t%0d", i), 16'(comp0[7]), 16'((i / 3) % 2));
    end
    keys = 48'h000000_000A0F;
    cyc();
    chk("turbo_real_a", comp0, 16'h0080);

    // Strobe held: reads return live A; then pads read independently.
    keys = 48'h000000_000E0A;
    cyc();
    wr_reg(1'b0, 8'h01);
    for (int i = 0; i < 4; i++) begin
      rd_reg(1'b0, d0, d1);
      chk($sformatf("strobe_rd%0d", i), 16'(d0), 16'h0001);
    end
    rd_reg(1'b1, d0, d1);
    chk("strobe_pad1", 16'(d0), 16'h0000);
    chk("onepad_addr1", 16'(d1), 16'h0000);
    wr_reg(1'b0, 8'h00);
    rd_reg(1'b1, d0, d1); chk("indep_p1_a", 16'(d0), 16'h0000);
    rd_reg(1'b0, d0, d1); chk("indep_p0_a", 16'(d0), 16'h0001);
    rd_reg(1'b1, d0, d1); chk("indep_p1_b", 16'(d0), 16'h0001);
    rd_reg(1'b0, d0, d1); chk("indep_p0_b", 16'(d0), 16'h0000);
    rd_reg(1'b1, d0, d1); chk("indep_p1_s", 16'(d0), 16'h0000);

    // Held read shifts once; RD with WR is a write only.
    keys = 48'h000000_00170A;
    cyc();
    wr_reg(1'b0, 8'h01);
    wr_reg(1'b0, 8'h00);
    set_bus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc();
    chk("held_rd_first", 16'(bus0.DATA), 16'h0001);
    for (int i = 0; i < 4; i++) cyc();
    set_bus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    cyc();
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc();
    rd_reg(1'b0, d0, d1); chk("held_rd_b", 16'(d0), 16'h0000);
    rd_reg(1'b0, d0, d1); chk("held_rd_sel", 16'(d0), 16'h0001);

    // Reset between reads 3 and 4 discards the sequence.
    wr_reg(1'b0, 8'h01);
    wr_reg(1'b0, 8'h00);
    rd_reg(1'b0, d0, d1); chk("rst_seq_rd1", 16'(d0), 16'h0001);
    rd_reg(1'b0, d0, d1); chk("rst_seq_rd2", 16'(d0), 16'h0000);
    rd_reg(1'b0, d0, d1); chk("rst_seq_rd3", 16'(d0), 16'h0001);
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_seq_data", 16'(bus0.DATA), 16'h0000);
    rst_n = 1'b1;
    cyc();
    rd_reg(1'b0, d0, d1); chk("rst_seq_rd4", 16'(d0), 16'h0000);

    // Simultaneous RD+WR writing strobe=1: write is taken.
    set_bus(1'b1, 1'b1, 1'b1, 1'b0, 8'h01);
    cyc();
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc();
    rd_reg(1'b0, d0, d1); chk("rdwr_strobe", 16'(d0), 16'h0001);
    wr_reg(1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
